// File: rtl/whack_pkg.sv
// Constants shared between the button front end and the whack-a-mole game core.
package whack_pkg;

  localparam int N_BTN                   = 8;
  localparam int IDX_W                   = $clog2(N_BTN);
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-FF synchroniser, stability counter and debounced level.
// rise is high in the cycle whose closing edge will raise the level.
module debounce_cell
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign rise  = level_d & ~level_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the player buttons and queues one hit event per press, handed to
// the game FSM lowest index first over a valid/ready handshake.
module button_conditioner #(
  parameter int N_BTN           = whack_pkg::N_BTN,
  parameter int DEBOUNCE_CYCLES = whack_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter int IDX_W           = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             press_valid,
  output logic [IDX_W-1:0] press_idx,
  input  logic             press_ready,
  output logic             overflow,
  input  logic             ovf_clr
);

  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] accept_mask;
  logic [N_BTN-1:0] drop;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx;
  logic             found;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_cell
      debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_raw[gi]),
        .level  (btn_level[gi]),
        .rise   (rise[gi])
      );
    end
  endgenerate

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (pend_q[i] && !found) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

  // A press landing on the bit being accepted replaces the consumed event.
  always_comb begin
    accept_mask = '0;
    if (press_valid && press_ready) begin
      accept_mask = N_BTN'(1) << press_idx;
    end
    drop   = rise & pend_q & ~accept_mask;
    pend_d = (pend_q & ~accept_mask) | rise;
    ovf_d  = ovf_q;
    if (|drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign press_valid = |pend_q;
  assign press_idx   = idx;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce window.
module tb_button_conditioner;

  localparam int N_BTN = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic             press_valid;
  logic [IDX_W-1:0] press_idx;
  logic             press_ready;
  logic             overflow;
  logic             ovf_clr;

  int n_checks = 0;
  int n_errors = 0;

  button_conditioner #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .press_valid(press_valid),
    .press_idx  (press_idx),
    .press_ready(press_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    btn_raw     = '0;
    press_ready = 1'b0;
    ovf_clr     = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_level"}, 32'(btn_level), 32'h0);
    check({tag, "_valid"}, 32'(press_valid), 32'h0);
    check({tag, "_idx"}, 32'(press_idx), 32'h0);
    check({tag, "_ovf"}, 32'(overflow), 32'h0);
  endtask

  logic seen_valid;
  logic seen_level;

  initial begin
    rst_n       = 1'b0;
    btn_raw     = '0;
    press_ready = 1'b0;
    ovf_clr     = 1'b0;
    tick(2);
    check_all_zero("por");
    rst_n = 1'b1;

    // 1. mid-run reset with buttons held, then button 6 held through release
    btn_raw = 8'h41;
    tick(8);
    check("t1_level_pre", 32'(btn_level), 32'h41);
    check("t1_idx_pre", 32'(press_idx), 32'h0);
    #3;
    rst_n   = 1'b0;
    btn_raw = 8'h40;
    #1;
    check_all_zero("t1_async");
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check("t1_valid_c5", 32'(press_valid), 32'h0);
    tick(1);
    check("t1_level_c6", 32'(btn_level), 32'h40);
    check("t1_valid_c6", 32'(press_valid), 32'h1);
    check("t1_idx_c6", 32'(press_idx), 32'h6);

    // 2. clean press, accept, release
    apply_reset();
    btn_raw = 8'h08;
    tick(5);
    check("t2_level_c5", 32'(btn_level), 32'h00);
    tick(1);
    check("t2_level_c6", 32'(btn_level), 32'h08);
    check("t2_valid_c6", 32'(press_valid), 32'h1);
    check("t2_idx_c6", 32'(press_idx), 32'h3);
    press_ready = 1'b1;
    tick(1);
    press_ready = 1'b0;
    check("t2_valid_acc", 32'(press_valid), 32'h0);
    btn_raw = 8'h00;
    tick(5);
    check("t2_rel_c5", 32'(btn_level), 32'h08);
    tick(1);
    check("t2_rel_c6", 32'(btn_level), 32'h00);
    check("t2_rel_valid", 32'(press_valid), 32'h0);

    // 3. bounce rejection
    apply_reset();
    seen_valid = 1'b0;
    seen_level = 1'b0;
    for (int c = 0; c < 50; c++) begin
      btn_raw[1] = (c < 40) ? 1'((c / 2) % 2 == 0) : 1'b0;
      tick(1);
      seen_valid |= press_valid;
      seen_level |= |btn_level;
    end
    check("t3_level", 32'(seen_level), 32'h0);
    check("t3_valid", 32'(seen_valid), 32'h0);

    // 4. priority between buttons 5 and 2
    apply_reset();
    btn_raw = 8'h24;
    tick(6);
    check("t4_level", 32'(btn_level), 32'h24);
    check("t4_idx_first", 32'(press_idx), 32'h2);
    press_ready = 1'b1;
    tick(1);
    check("t4_valid_second", 32'(press_valid), 32'h1);
    check("t4_idx_second", 32'(press_idx), 32'h5);
    tick(1);
    press_ready = 1'b0;
    check("t4_valid_empty", 32'(press_valid), 32'h0);
    check("t4_idx_empty", 32'(press_idx), 32'h0);

    // 5. overflow set, clear, and set-wins-over-clear
    apply_reset();
    btn_raw = 8'h04;
    tick(6);
    check("t5_idx_first", 32'(press_idx), 32'h2);
    btn_raw = 8'h00;
    tick(6);
    btn_raw = 8'h04;
    tick(5);
    check("t5_ovf_c5", 32'(overflow), 32'h0);
    tick(1);
    check("t5_ovf_c6", 32'(overflow), 32'h1);
    check("t5_valid", 32'(press_valid), 32'h1);
    press_ready = 1'b1;
    tick(1);
    press_ready = 1'b0;
    check("t5_single_event", 32'(press_valid), 32'h0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t5_ovf_clr", 32'(overflow), 32'h0);
    btn_raw = 8'h00;
    tick(6);
    btn_raw = 8'h04;
    tick(6);
    check("t5_repend_ovf", 32'(overflow), 32'h0);
    btn_raw = 8'h00;
    tick(6);
    btn_raw = 8'h04;
    tick(5);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t5_set_wins", 32'(overflow), 32'h1);
    tick(1);
    check("t5_sticky", 32'(overflow), 32'h1);

    // 6. new press on button 0 lands on its accept edge
    apply_reset();
    btn_raw = 8'h01;
    tick(6);
    btn_raw = 8'h00;
    tick(6);
    check("t6_pend_held", 32'(press_valid), 32'h1);
    btn_raw = 8'h01;
    tick(5);
    press_ready = 1'b1;
    tick(1);
    press_ready = 1'b0;
    check("t6_valid", 32'(press_valid), 32'h1);
    check("t6_idx", 32'(press_idx), 32'h0);
    check("t6_ovf", 32'(overflow), 32'h0);
    press_ready = 1'b1;
    tick(1);
    press_ready = 1'b0;
    check("t6_drained", 32'(press_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
